// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder.
// Holds the hex glyph table (active-high, {a,b,c,d,e,f,g,dp}), the same table the hex encoder
// uses, plus small helpers shared by the decoder top level and its pattern-decode sub-module.
package seg7_scan_decoder_pkg;

  // Active-high glyphs, bit7 = segment a ... bit1 = segment g, bit0 = decimal point (always 0 here)
  localparam logic [7:0] SEG7_GLYPH_0 = 8'hFC;
  localparam logic [7:0] SEG7_GLYPH_1 = 8'h60;
  localparam logic [7:0] SEG7_GLYPH_2 = 8'hDA;
  localparam logic [7:0] SEG7_GLYPH_3 = 8'hF2;
  localparam logic [7:0] SEG7_GLYPH_4 = 8'h66;
  localparam logic [7:0] SEG7_GLYPH_5 = 8'hB6;
  localparam logic [7:0] SEG7_GLYPH_6 = 8'hBE;
  localparam logic [7:0] SEG7_GLYPH_7 = 8'hE0;
  localparam logic [7:0] SEG7_GLYPH_8 = 8'hFE;
  localparam logic [7:0] SEG7_GLYPH_9 = 8'hF6;
  localparam logic [7:0] SEG7_GLYPH_A = 8'hEE;
  localparam logic [7:0] SEG7_GLYPH_B = 8'h3E;
  localparam logic [7:0] SEG7_GLYPH_C = 8'h9C;
  localparam logic [7:0] SEG7_GLYPH_D = 8'h7A;
  localparam logic [7:0] SEG7_GLYPH_E = 8'h9E;
  localparam logic [7:0] SEG7_GLYPH_F = 8'h8E;

  // Position of the decimal point inside a segment byte
  localparam int SEG7_DP_BIT = 0;

  // Number of distinct hex glyphs
  localparam int SEG7_N_GLYPHS = 16;

  // Classification of the anode bus during a stable window
  typedef enum logic [1:0] {
    AN_NONE  = 2'd0,  // all anodes high: display blanked between digits
    AN_ONE   = 2'd1,  // exactly one digit selected
    AN_MULTI = 2'd2   // bus fault: several digits selected at once
  } an_class_t;

  // Glyph lookup by nibble; usable in constant context
  function automatic logic [7:0] seg7_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = SEG7_GLYPH_0;
      4'h1: g = SEG7_GLYPH_1;
      4'h2: g = SEG7_GLYPH_2;
      4'h3: g = SEG7_GLYPH_3;
      4'h4: g = SEG7_GLYPH_4;
      4'h5: g = SEG7_GLYPH_5;
      4'h6: g = SEG7_GLYPH_6;
      4'h7: g = SEG7_GLYPH_7;
      4'h8: g = SEG7_GLYPH_8;
      4'h9: g = SEG7_GLYPH_9;
      4'hA: g = SEG7_GLYPH_A;
      4'hB: g = SEG7_GLYPH_B;
      4'hC: g = SEG7_GLYPH_C;
      4'hD: g = SEG7_GLYPH_D;
      4'hE: g = SEG7_GLYPH_E;
      default: g = SEG7_GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder.
// Maps an active-high a..g pattern back to its hex nibble; o_hit is low when the
// pattern is not one of the sixteen hex glyphs (o_nibble is then 0 and must be ignored).
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pat,     // active-high {a,b,c,d,e,f,g}
  output logic [3:0] o_nibble,
  output logic       o_hit
);

  logic [SEG7_N_GLYPHS-1:0] w_match;

  // One comparator per glyph; the glyph patterns are all distinct so at most one matches
  generate
    for (genvar gi = 0; gi < SEG7_N_GLYPHS; gi++) begin : g_match
      localparam logic [7:0] GLYPH = seg7_glyph(4'(gi));
      assign w_match[gi] = (i_pat == GLYPH[7:1]);
    end
  endgenerate

  // Encode the single matching comparator into its nibble
  always_comb begin
    o_nibble = 4'h0;
    o_hit    = |w_match;
    for (int k = 0; k < SEG7_N_GLYPHS; k++) begin
      if (w_match[k]) begin
        o_nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus monitor.
// Samples the active-low segment and anode lines, waits until they have been steady for
// STABLE_CYC consecutive samples, then decodes the selected digit back to a hex nibble and
// stores it in a per-digit register file. Also reports completed scan frames and sticky
// errors for non-glyph patterns and multiple simultaneously selected anodes.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  i_seg_in,
  input  logic [N_DIGITS-1:0]         i_an_in,
  input  logic                        i_err_clr,
  output logic [4*N_DIGITS-1:0]       o_hex_out,
  output logic [N_DIGITS-1:0]         o_dp_out,
  output logic [N_DIGITS-1:0]         o_valid,
  output logic                        o_upd,
  output logic [$clog2(N_DIGITS)-1:0] o_upd_idx,
  output logic                        o_frame_done,
  output logic                        o_err_pat,
  output logic                        o_err_multi
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int SMP_W = 8 + N_DIGITS;
  localparam logic [N_DIGITS-1:0] ONE_N = {{(N_DIGITS-1){1'b0}}, 1'b1};

  // Sampling and stability tracking
  logic [SMP_W-1:0]    w_sample;
  logic [SMP_W-1:0]    r_s1;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_same;
  logic                w_capture;

  // Anode decode
  logic [N_DIGITS-1:0] w_an_act;
  logic                w_an_any;
  logic                w_an_single;
  an_class_t           w_an_class;
  logic [IDX_W-1:0]    w_an_idx;

  // Pattern decode
  logic [7:0]          w_seg_act;
  logic [3:0]          w_dec_nibble;
  logic                w_dec_hit;

  // Capture qualification
  logic                w_cap_one;
  logic                w_cap_multi;
  logic                w_set_pat;
  logic [N_DIGITS-1:0] w_wr_en;
  logic [N_DIGITS-1:0] w_seen_next;
  logic                w_frame_full;

  // Register file and status
  logic [3:0]          r_hex [N_DIGITS];
  logic [N_DIGITS-1:0] r_dp;
  logic [N_DIGITS-1:0] r_valid;
  logic [N_DIGITS-1:0] r_seen;
  logic                r_upd;
  logic [IDX_W-1:0]    r_upd_idx;
  logic                r_frame_done;
  logic                r_err_pat;
  logic                r_err_multi;

  assign w_sample  = {i_seg_in, i_an_in};
  assign w_same    = (w_sample == r_s1);
  // The counter passes STABLE_CYC-1 exactly once per window before saturating,
  // so a held pattern produces a single capture however long it stays.
  assign w_capture = w_same && (r_cnt == CNT_W'(STABLE_CYC - 1));

  // Previous-sample register and saturating run-length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= w_sample;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt < CNT_W'(STABLE_CYC)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Anode lines are active-low; classify how many digits are selected.
  // x & (x-1) clears the lowest set bit, so it is zero only for a single set bit.
  assign w_an_act    = ~i_an_in;
  assign w_an_any    = |w_an_act;
  assign w_an_single = w_an_any && ((w_an_act & (w_an_act - ONE_N)) == '0);

  // Anode classification used by the capture qualification below
  always_comb begin
    w_an_class = AN_NONE;
    if (w_an_single) begin
      w_an_class = AN_ONE;
    end else if (w_an_any) begin
      w_an_class = AN_MULTI;
    end
  end

  // Index of the selected digit; only meaningful when exactly one anode is low
  always_comb begin
    w_an_idx = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_an_act[k]) begin
        w_an_idx = IDX_W'(k);
      end
    end
  end

  // Segment lines are active-low; dp sits in the low bit and is not part of the glyph
  assign w_seg_act = ~i_seg_in;

  seg7_pattern_decode u_pattern_decode (
    .i_pat    (w_seg_act[7:1]),
    .o_nibble (w_dec_nibble),
    .o_hit    (w_dec_hit)
  );

  assign w_cap_one    = w_capture && (w_an_class == AN_ONE);
  assign w_cap_multi  = w_capture && (w_an_class == AN_MULTI);
  assign w_set_pat    = w_cap_one && !w_dec_hit;
  assign w_seen_next  = r_seen | w_an_act;
  assign w_frame_full = &w_seen_next;

  // Per-digit write enables and output mapping of the register file
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign w_wr_en[gi]            = w_cap_one && w_an_act[gi];
      assign o_hex_out[4*gi +: 4]   = r_hex[gi];
    end
  endgenerate

  // Register file: nibble only replaced on a legal glyph, validity and dp on every capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        r_hex[k] <= 4'h0;
      end
      r_dp    <= '0;
      r_valid <= '0;
    end else begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_wr_en[k]) begin
          r_dp[k]    <= w_seg_act[SEG7_DP_BIT];
          r_valid[k] <= w_dec_hit;
          if (w_dec_hit) begin
            r_hex[k] <= w_dec_nibble;
          end
        end
      end
    end
  end

  // Update/frame pulses and the seen-digit mask; a repeated digit does not advance the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd        <= 1'b0;
      r_upd_idx    <= '0;
      r_frame_done <= 1'b0;
      r_seen       <= '0;
    end else begin
      r_upd        <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_cap_one) begin
        r_upd     <= 1'b1;
        r_upd_idx <= w_an_idx;
        if (w_frame_full) begin
          r_frame_done <= 1'b1;
          r_seen       <= '0;
        end else begin
          r_seen <= w_seen_next;
        end
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pat   <= 1'b0;
      r_err_multi <= 1'b0;
    end else begin
      if (w_set_pat) begin
        r_err_pat <= 1'b1;
      end else if (i_err_clr) begin
        r_err_pat <= 1'b0;
      end
      if (w_cap_multi) begin
        r_err_multi <= 1'b1;
      end else if (i_err_clr) begin
        r_err_multi <= 1'b0;
      end
    end
  end

  assign o_dp_out     = r_dp;
  assign o_valid      = r_valid;
  assign o_upd        = r_upd;
  assign o_upd_idx    = r_upd_idx;
  assign o_frame_done = r_frame_done;
  assign o_err_pat    = r_err_pat;
  assign o_err_multi  = r_err_multi;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (N_DIGITS=8, STABLE_CYC=4).
// Directed table of bus windows with hand-derived results, an asynchronous reset
// sequence, then randomized windows checked every cycle against a run-length model.
module tb_seg7_scan_decoder;

  localparam int N  = 8;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [7:0]  an = 8'hFF;
  logic        err_clr = 1'b0;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        frame_done;
  logic        err_pat;
  logic        err_multi;

  int checks = 0;
  int errors = 0;

  seg7_scan_decoder #(.N_DIGITS(N), .STABLE_CYC(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_seg_in     (seg),
    .i_an_in      (an),
    .i_err_clr    (err_clr),
    .o_hex_out    (hex_out),
    .o_dp_out     (dp_out),
    .o_valid      (valid),
    .o_upd        (upd),
    .o_upd_idx    (upd_idx),
    .o_frame_done (frame_done),
    .o_err_pat    (err_pat),
    .o_err_multi  (err_multi)
  );

  always #5 clk = ~clk;

  // Hex glyphs, active-high {a..g,dp}
  logic [7:0] glyphs [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // ---------------- reference model ----------------
  // A window is captured when the same {seg,an} value has been seen on STABLE_CYC+1
  // consecutive edges; the reset state counts as one prior sample of value zero.
  logic [15:0] m_last;
  int          m_run;
  logic [3:0]  m_hex [N];
  bit          m_dp [N];
  bit          m_valid [N];
  bit          m_seen [N];
  bit          m_upd, m_frame, m_ep, m_em;
  int          m_idx;

  task automatic model_reset();
    m_last = '0;
    m_run = 1;
    for (int i = 0; i < N; i++) begin
      m_hex[i] = 4'h0; m_dp[i] = 0; m_valid[i] = 0; m_seen[i] = 0;
    end
    m_upd = 0; m_frame = 0; m_ep = 0; m_em = 0; m_idx = 0;
  endtask

  task automatic model_edge();
    logic [15:0] x;
    logic [7:0]  pat;
    int zeros, pos, nib;
    bit set_p, set_m, all;
    x = {seg, an};
    if (x == m_last) m_run++; else m_run = 1;
    m_last = x;
    m_upd = 0; m_frame = 0; set_p = 0; set_m = 0; pos = 0;
    if (m_run == SC + 1) begin
      zeros = 0;
      for (int i = 0; i < N; i++) if (!an[i]) begin zeros++; pos = i; end
      if (zeros > 1) set_m = 1;
      else if (zeros == 1) begin
        m_upd = 1;
        m_idx = pos;
        m_dp[pos] = !seg[0];
        pat = ~seg & 8'hFE;
        nib = -1;
        for (int g = 0; g < 16; g++) if (pat == glyphs[g]) nib = g;
        if (nib >= 0) begin m_hex[pos] = 4'(nib); m_valid[pos] = 1; end
        else begin m_valid[pos] = 0; set_p = 1; end
        m_seen[pos] = 1;
        all = 1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
        if (all) begin
          m_frame = 1;
          for (int i = 0; i < N; i++) m_seen[i] = 0;
        end
      end
    end
    if (set_p) m_ep = 1; else if (err_clr) m_ep = 0;
    if (set_m) m_em = 1; else if (err_clr) m_em = 0;
  endtask

  function automatic logic [31:0] m_hex_bus();
    logic [31:0] b;
    for (int i = 0; i < N; i++) b[4*i +: 4] = m_hex[i];
    return b;
  endfunction

  function automatic logic [7:0] m_bits(input int which);
    logic [7:0] b;
    for (int i = 0; i < N; i++) b[i] = (which == 0) ? m_dp[i] : m_valid[i];
    return b;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".hex_out"},    hex_out,    m_hex_bus());
    chk({tag, ".dp_out"},     32'(dp_out), 32'(m_bits(0)));
    chk({tag, ".valid"},      32'(valid),  32'(m_bits(1)));
    chk({tag, ".upd"},        32'(upd),    32'(m_upd));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_frame));
    chk({tag, ".err_pat"},    32'(err_pat),    32'(m_ep));
    chk({tag, ".err_multi"},  32'(err_multi),  32'(m_em));
    if (m_upd) chk({tag, ".upd_idx"}, 32'(upd_idx), 32'(m_idx));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".hex_out"},    hex_out, 32'h0);
    chk({tag, ".dp_out"},     32'(dp_out), 32'h0);
    chk({tag, ".valid"},      32'(valid), 32'h0);
    chk({tag, ".upd"},        32'(upd), 32'h0);
    chk({tag, ".upd_idx"},    32'(upd_idx), 32'h0);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, ".err_pat"},    32'(err_pat), 32'h0);
    chk({tag, ".err_multi"},  32'(err_multi), 32'h0);
  endtask

  // One clock: inputs were set before the edge, model advances on it, outputs checked at negedge
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  an;
    logic [7:0]  seg;
    int          hold;
    int          clr_at;   // cycle within the window with err_clr high, 0 = none
    int          n_upd;
    int          n_frame;
    logic [31:0] hex;
    logic [7:0]  valid;
    logic [7:0]  dp;
    logic        ep;
    logic        em;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] a, logic [7:0] s, int h, int c, int nu, int nf,
                              logic [31:0] hx, logic [7:0] v, logic [7:0] d, logic ep, logic em);
    vec_t e;
    e.an = a; e.seg = s; e.hold = h; e.clr_at = c; e.n_upd = nu; e.n_frame = nf;
    e.hex = hx; e.valid = v; e.dp = d; e.ep = ep; e.em = em;
    return e;
  endfunction

  initial begin
    int n_upd, n_frame, first;
    string tag;

    // Windows in order; expectations are cumulative display state after each window
    tbl.push_back(mk(8'hFE, ~8'hDA, 8, 0, 1, 0, 32'h00000002, 8'h01, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFD, ~8'h61, 3, 0, 0, 0, 32'h00000002, 8'h01, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFD, ~8'hF3, 5, 0, 1, 0, 32'h00000032, 8'h03, 8'h02, 0, 0));
    tbl.push_back(mk(8'hF7, ~8'h02, 5, 0, 1, 0, 32'h00000032, 8'h03, 8'h02, 1, 0));
    tbl.push_back(mk(8'hFF, ~8'h02, 2, 1, 0, 0, 32'h00000032, 8'h03, 8'h02, 0, 0));
    tbl.push_back(mk(8'hF7, ~8'h02, 5, 5, 1, 0, 32'h00000032, 8'h03, 8'h02, 1, 0));
    tbl.push_back(mk(8'hFF, ~8'h02, 2, 1, 0, 0, 32'h00000032, 8'h03, 8'h02, 0, 0));
    tbl.push_back(mk(8'hFC, ~8'hFC, 5, 0, 0, 0, 32'h00000032, 8'h03, 8'h02, 0, 1));
    tbl.push_back(mk(8'hFF, ~8'hFC, 5, 0, 0, 0, 32'h00000032, 8'h03, 8'h02, 0, 1));
    tbl.push_back(mk(8'hFF, ~8'hFC, 2, 1, 0, 0, 32'h00000032, 8'h03, 8'h02, 0, 0));
    tbl.push_back(mk(8'hFE, ~8'hFC, 5, 0, 1, 0, 32'h00000030, 8'h03, 8'h02, 0, 0));
    tbl.push_back(mk(8'hFD, ~8'h60, 5, 0, 1, 0, 32'h00000010, 8'h03, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFB, ~8'hDA, 5, 0, 1, 0, 32'h00000210, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk(8'hF7, ~8'hF2, 5, 0, 1, 0, 32'h00003210, 8'h0F, 8'h00, 0, 0));
    tbl.push_back(mk(8'hEF, ~8'h66, 5, 0, 1, 0, 32'h00043210, 8'h1F, 8'h00, 0, 0));
    tbl.push_back(mk(8'hDF, ~8'hB6, 5, 0, 1, 0, 32'h00543210, 8'h3F, 8'h00, 0, 0));
    tbl.push_back(mk(8'hBF, ~8'hBE, 5, 0, 1, 0, 32'h06543210, 8'h7F, 8'h00, 0, 0));
    tbl.push_back(mk(8'h7F, ~8'hE0, 5, 0, 1, 1, 32'h76543210, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFE, ~8'hFE, 5, 0, 1, 0, 32'h76543218, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFD, ~8'hF6, 5, 0, 1, 0, 32'h76543298, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFB, ~8'hEE, 5, 0, 1, 0, 32'h76543A98, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(8'hF7, ~8'h3E, 5, 0, 1, 0, 32'h7654BA98, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(8'hFE, ~8'hFF, 5, 0, 1, 0, 32'h7654BA98, 8'hFF, 8'h01, 0, 0));
    tbl.push_back(mk(8'hEF, ~8'h9C, 5, 0, 1, 0, 32'h765CBA98, 8'hFF, 8'h01, 0, 0));
    tbl.push_back(mk(8'hDF, ~8'h7A, 5, 0, 1, 0, 32'h76DCBA98, 8'hFF, 8'h01, 0, 0));
    tbl.push_back(mk(8'hBF, ~8'h9E, 5, 0, 1, 0, 32'h7EDCBA98, 8'hFF, 8'h01, 0, 0));
    tbl.push_back(mk(8'h7F, ~8'h8E, 5, 0, 1, 1, 32'hFEDCBA98, 8'hFF, 8'h01, 0, 0));

    // Reset state
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Directed windows
    foreach (tbl[v]) begin
      n_upd = 0; n_frame = 0; first = 0;
      for (int c = 1; c <= tbl[v].hold; c++) begin
        an = tbl[v].an;
        seg = tbl[v].seg;
        err_clr = (c == tbl[v].clr_at);
        step($sformatf("vec%0d.c%0d", v, c));
        if (upd) begin
          n_upd++;
          if (first == 0) first = c;
        end
        if (frame_done) n_frame++;
      end
      err_clr = 1'b0;
      tag = $sformatf("vec%0d", v);
      chk({tag, ".upd_count"},   32'(n_upd), 32'(tbl[v].n_upd));
      chk({tag, ".frame_count"}, 32'(n_frame), 32'(tbl[v].n_frame));
      chk({tag, ".hex_out"},     hex_out, tbl[v].hex);
      chk({tag, ".valid"},       32'(valid), 32'(tbl[v].valid));
      chk({tag, ".dp_out"},      32'(dp_out), 32'(tbl[v].dp));
      chk({tag, ".err_pat"},     32'(err_pat), 32'(tbl[v].ep));
      chk({tag, ".err_multi"},   32'(err_multi), 32'(tbl[v].em));
      if (tbl[v].n_upd > 0) chk({tag, ".upd_edge"}, 32'(first), 32'(SC + 1));
    end

    // Reset in the middle of a valid window, then a full window after release
    an = 8'hFB;
    seg = ~8'hB6;
    for (int c = 1; c <= 3; c++) step($sformatf("rstwin.c%0d", c));
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      step($sformatf("postrst.c%0d", c));
      if (upd && first == 0) first = c;
    end
    chk("postrst.upd_edge", 32'(first), 32'(SC + 1));
    chk("postrst.hex_out", hex_out, 32'h00000500);

    // Randomized windows, including glitches shorter than the stable window
    for (int w = 0; w < 400; w++) begin
      int kind, hold, a, b;
      kind = $urandom_range(0, 9);
      if (kind <= 6) an = ~(8'h01 << $urandom_range(0, N - 1));
      else if (kind == 7) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        an = ~((8'h01 << a) | (8'h01 << b));
      end else if (kind == 8) an = 8'hFF;
      else an = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        seg = ~(glyphs[$urandom_range(0, 15)] | 8'($urandom_range(0, 1)));
      else
        seg = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 1; c <= hold; c++) begin
        err_clr = ($urandom_range(0, 7) == 0);
        step($sformatf("rnd%0d.c%0d", w, c));
      end
    end
    err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
